hub75_frame_buffer: RTL and testbench

- Double-buffered pixel store that feeds the HUB75 scan controller.
- A host-side port writes 3-bit RGB pixels into the back bank. The scan side reads the front bank by (row, column) and gets top-half and bottom-half colours together.
- A host swap request is honoured only at a scanner frame boundary, so the displayed image never tears.

---
 rtl/hub75_fb_pkg.sv | 13 +
 rtl/fb_bank_ram.sv | 30 +++
 rtl/hub75_frame_buffer.sv | 197 +++++++++++++++++++
 tb/tb_hub75_frame_buffer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_fb_pkg.sv
// Shared types and widths for the HUB75 frame buffer.
package hub75_fb_pkg;

    localparam int unsigned FB_ADDR_W = 10;
    localparam int unsigned FB_RGB_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SWAP_WAIT = 2'd1,
        ST_CLEAR     = 2'd2
    } fb_state_e;

endpackage

// File: rtl/fb_bank_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// Sized for the largest panel (32 columns x 32 rows per half).
module fb_bank_ram
    import hub75_fb_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [FB_ADDR_W-1:0] waddr_i,
    input  logic [FB_RGB_W-1:0]  wdata_i,
    input  logic                 re_i,
    input  logic [FB_ADDR_W-1:0] raddr_i,
    output logic [FB_RGB_W-1:0]  rdata_o
);

    logic [FB_RGB_W-1:0] mem_q [2**FB_ADDR_W];
    logic [FB_RGB_W-1:0] rdata_q;

    // Write port and read register; read data holds while re_i is low.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hub75_frame_buffer.sv
// Double-buffered HUB75 pixel store. The host writes the back bank, the
// scanner reads the front bank; bank swaps take effect only on frame_end.
// Optional: FB_CLEAR_ON_SWAP_EN zeroes the new back bank after every flip
// and after reset.
module hub75_frame_buffer
    import hub75_fb_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH = 32,
    parameter int unsigned SCREEN_DEPTH = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [5:0] wr_x,
    input  logic [5:0] wr_y,
    input  logic [2:0] wr_rgb,
    input  logic       swap_req,
    output logic       swap_pending,
    output logic       swap_done,
    input  logic       frame_end,
    input  logic       rd_en,
    input  logic [4:0] rd_row,
    input  logic [4:0] rd_col,
    output logic       R1_data,
    output logic       G1_data,
    output logic       B1_data,
    output logic       R2_data,
    output logic       G2_data,
    output logic       B2_data,
    output logic       rd_valid,
    output logic       front_bank
);

    localparam logic [6:0]           W_LIM = 7'(SCREEN_WIDTH);
    localparam logic [6:0]           D_LIM = 7'(SCREEN_DEPTH);
    localparam logic [6:0]           H_LIM = 7'(2 * SCREEN_DEPTH);
    localparam logic [FB_ADDR_W-1:0] W_MUL = FB_ADDR_W'(SCREEN_WIDTH);

    fb_state_e state_q, state_d;
    logic      front_bank_q;
    logic      swap_done_q;
    logic      flip;
`ifdef FB_CLEAR_ON_SWAP_EN
    localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(SCREEN_WIDTH * SCREEN_DEPTH - 1);
    logic [FB_ADDR_W-1:0] clr_addr_q, clr_addr_d;
`endif

    // Next-state logic: a swap waits for frame_end; requests are never queued.
    always_comb begin
        state_d = state_q;
        flip    = 1'b0;
`ifdef FB_CLEAR_ON_SWAP_EN
        clr_addr_d = clr_addr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (swap_req) state_d = ST_SWAP_WAIT;
            end
            ST_SWAP_WAIT: begin
                if (frame_end) begin
                    flip = 1'b1;
`ifdef FB_CLEAR_ON_SWAP_EN
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef FB_CLEAR_ON_SWAP_EN
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == CLR_LAST) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset discards any pending swap.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
`ifdef FB_CLEAR_ON_SWAP_EN
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
`else
            state_q <= ST_IDLE;
`endif
            front_bank_q <= 1'b0;
            swap_done_q  <= 1'b0;
        end else begin
`ifdef FB_CLEAR_ON_SWAP_EN
            clr_addr_q <= clr_addr_d;
`endif
            state_q      <= state_d;
            front_bank_q <= front_bank_q ^ flip;
            swap_done_q  <= flip;
        end
    end

    assign wr_ready     = (state_q == ST_IDLE);
    assign swap_pending = (state_q == ST_SWAP_WAIT);
    assign swap_done    = swap_done_q;
    assign front_bank   = front_bank_q;

    // Host write decode: panel row picks the half; out-of-range is dropped.
    logic [6:0]           wr_x7, wr_y7, wr_row7;
    logic                 wr_top, wr_in_range;
    logic                 we_top, we_bot;
    logic [FB_ADDR_W-1:0] ram_waddr;
    logic [FB_RGB_W-1:0]  ram_wdata;

    assign wr_x7       = {1'b0, wr_x};
    assign wr_y7       = {1'b0, wr_y};
    assign wr_top      = (wr_y7 < D_LIM);
    assign wr_in_range = (wr_x7 < W_LIM) && (wr_y7 < H_LIM);
    assign wr_row7     = wr_top ? wr_y7 : (wr_y7 - D_LIM);

    // Back-bank write port mux: clearing overrides host writes.
    always_comb begin
        we_top    = wr_valid && wr_ready && wr_in_range && wr_top;
        we_bot    = wr_valid && wr_ready && wr_in_range && !wr_top;
        ram_waddr = FB_ADDR_W'(wr_row7) * W_MUL + FB_ADDR_W'(wr_x7);
        ram_wdata = wr_rgb;
`ifdef FB_CLEAR_ON_SWAP_EN
        if (state_q == ST_CLEAR) begin
            we_top    = 1'b1;
            we_bot    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = '0;
        end
`endif
    end

    // Scanner read: both halves share one address within their own array.
    logic                 rd_in_range, rd_fire;
    logic [FB_ADDR_W-1:0] rd_addr;
    logic                 rd_valid_q, rd_ok_q, rd_bank_q;

    assign rd_in_range = ({2'b00, rd_row} < D_LIM) && ({2'b00, rd_col} < W_LIM);
    assign rd_fire     = rd_en && rd_in_range;
    assign rd_addr     = FB_ADDR_W'(rd_row) * W_MUL + FB_ADDR_W'(rd_col);

    // Read-side tags: bank and range are captured with the read, so a flip
    // in the read cycle still returns old-bank data.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_valid_q <= 1'b0;
            rd_ok_q    <= 1'b0;
            rd_bank_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_ok_q   <= rd_in_range;
                rd_bank_q <= front_bank_q;
            end
        end
    end

    logic [FB_RGB_W-1:0] top_rdata [2];
    logic [FB_RGB_W-1:0] bot_rdata [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic sel_wr;
        assign sel_wr = (front_bank_q != 1'(b)) && !rst_in;

        fb_bank_ram u_top (
            .clk_i   (clk_in),
            .we_i    (sel_wr && we_top),
            .waddr_i (ram_waddr),
            .wdata_i (ram_wdata),
            .re_i    (rd_fire),
            .raddr_i (rd_addr),
            .rdata_o (top_rdata[b])
        );

        fb_bank_ram u_bot (
            .clk_i   (clk_in),
            .we_i    (sel_wr && we_bot),
            .waddr_i (ram_waddr),
            .wdata_i (ram_wdata),
            .re_i    (rd_fire),
            .raddr_i (rd_addr),
            .rdata_o (bot_rdata[b])
        );
    end

    logic [FB_RGB_W-1:0] top_pix, bot_pix;
    assign top_pix = rd_ok_q ? top_rdata[rd_bank_q] : '0;
    assign bot_pix = rd_ok_q ? bot_rdata[rd_bank_q] : '0;

    assign {R1_data, G1_data, B1_data} = top_pix;
    assign {R2_data, G2_data, B2_data} = bot_pix;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Self-checking bench for hub75_frame_buffer against a panel-level model.
module tb_hub75_frame_buffer;

    localparam int W = 32;
    localparam int D = 16;

    logic       clk_in = 1'b0;
    logic       rst_in, wr_valid, wr_ready, swap_req, swap_pending, swap_done;
    logic       frame_end, rd_en, rd_valid, front_bank;
    logic [5:0] wr_x, wr_y;
    logic [2:0] wr_rgb;
    logic [4:0] rd_row, rd_col;
    logic       R1_data, G1_data, B1_data, R2_data, G2_data, B2_data;

    always #5 clk_in = ~clk_in;

    hub75_frame_buffer #(.SCREEN_WIDTH(W), .SCREEN_DEPTH(D)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
        .swap_req(swap_req), .swap_pending(swap_pending), .swap_done(swap_done),
        .frame_end(frame_end),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .R1_data(R1_data), .G1_data(G1_data), .B1_data(B1_data),
        .R2_data(R2_data), .G2_data(G2_data), .B2_data(B2_data),
        .rd_valid(rd_valid), .front_bank(front_bank)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: whole panel image per bank, indexed [bank][panel row][column].
    logic [2:0] mm [2][2*D][W];
    int         mfront;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_flip();
        mfront = 1 - mfront;
`ifdef FB_CLEAR_ON_SWAP_EN
        for (int y = 0; y < 2*D; y++)
            for (int x = 0; x < W; x++)
                mm[1-mfront][y][x] = 3'b000;
`endif
    endtask

    // Waits (bounded) for wr_ready; with check_len, the number of low cycles
    // must be the clear length, or no wait at all without the clear feature.
    task automatic wait_ready(input int start, input bit check_len);
        int cnt = start;
        while (wr_ready !== 1'b1 && cnt < 3000) begin
            cnt++;
            tick();
        end
        if (cnt >= 3000) chk("wr_ready_timeout", 32'(wr_ready), 1);
`ifdef FB_CLEAR_ON_SWAP_EN
        if (check_len) chk("clear_len", cnt, 512);
`else
        if (check_len) chk("no_clear_wait", cnt, start);
`endif
    endtask

    task automatic do_write(input int x, input int y, input logic [2:0] rgb);
        wait_ready(0, 1'b0);
        wr_valid = 1'b1; wr_x = 6'(x); wr_y = 6'(y); wr_rgb = rgb;
        tick();
        wr_valid = 1'b0;
        if (x < W && y < 2*D) mm[1-mfront][y][x] = rgb;
    endtask

    task automatic do_read(input int row, input int col);
        logic [2:0] et, eb;
        et = 3'b000; eb = 3'b000;
        if (row < D && col < W) begin
            et = mm[mfront][row][col];
            eb = mm[mfront][row+D][col];
        end
        rd_en = 1'b1; rd_row = 5'(row); rd_col = 5'(col);
        tick();
        rd_en = 1'b0;
        chk("rd_top", 32'({R1_data, G1_data, B1_data}), 32'(et));
        chk("rd_bot", 32'({R2_data, G2_data, B2_data}), 32'(eb));
        chk("rd_valid", 32'(rd_valid), 1);
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("swap_pending_set", 32'(swap_pending), 1);
        chk("wr_ready_in_wait", 32'(wr_ready), 0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        model_flip();
        chk("front_bank_flip", 32'(front_bank), 32'(mfront));
        chk("swap_done_pulse", 32'(swap_done), 1);
        chk("swap_pending_clr", 32'(swap_pending), 0);
        tick();
        chk("swap_done_low", 32'(swap_done), 0);
        wait_ready(1, 1'b1);
    endtask

    task automatic fill_back();
        for (int y = 0; y < 2*D; y++)
            for (int x = 0; x < W; x++)
                do_write(x, y, 3'($urandom_range(0, 7)));
    endtask

    task automatic scan_front();
        for (int r = 0; r < D; r++)
            for (int c = 0; c < W; c++)
                do_read(r, c);
    endtask

    initial begin
        logic [2:0] r3, et, eb;
        int rr, cc;

        rst_in = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
        swap_req = 1'b0; frame_end = 1'b0; rd_en = 1'b0; rd_row = '0; rd_col = '0;
        mfront = 0;
        for (int b = 0; b < 2; b++)
            for (int y = 0; y < 2*D; y++)
                for (int x = 0; x < W; x++)
                    mm[b][y][x] = 3'b000;
        repeat (3) tick();

        // Reset values
        chk("rst_front_bank", 32'(front_bank), 0);
        chk("rst_swap_pending", 32'(swap_pending), 0);
        chk("rst_swap_done", 32'(swap_done), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_colours", 32'({R1_data, G1_data, B1_data, R2_data, G2_data, B2_data}), 0);
`ifdef FB_CLEAR_ON_SWAP_EN
        chk("rst_wr_ready", 32'(wr_ready), 0);
`else
        chk("rst_wr_ready", 32'(wr_ready), 1);
`endif
        rst_in = 1'b0;
        wait_ready(0, 1'b1);

        // Test 1: basic write, swap, read
        fill_back();
        do_write(0, 0, 3'b100);
        do_write(0, 16, 3'b000);
        do_write(5, 16, 3'b010);
        do_swap();
        do_read(0, 0);
        do_read(0, 5);
        fill_back();
        do_swap();
        for (int i = 0; i < 24; i++)
            do_read($urandom_range(0, 20), $urandom_range(0, 31));

        // Test 2: frame_end in IDLE ignored; request and frame_end together
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        chk("idle_frame_end_bank", 32'(front_bank), 32'(mfront));
        chk("idle_frame_end_done", 32'(swap_done), 0);
        swap_req = 1'b1; frame_end = 1'b1;
        tick();
        swap_req = 1'b0; frame_end = 1'b0;
        chk("same_cycle_pending", 32'(swap_pending), 1);
        chk("same_cycle_bank", 32'(front_bank), 32'(mfront));
        repeat (3) tick();
        chk("still_pending", 32'(swap_pending), 1);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        model_flip();
        chk("late_flip_bank", 32'(front_bank), 32'(mfront));
        chk("late_flip_done", 32'(swap_done), 1);
        tick();
        wait_ready(1, 1'b1);

        // Test 3: write held through SWAP_WAIT lands after the flip
        r3 = 3'($urandom_range(1, 7));
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        wr_valid = 1'b1; wr_x = 6'd3; wr_y = 6'd20; wr_rgb = r3;
        for (int i = 0; i < 4; i++) begin
            chk("wait_wr_ready", 32'(wr_ready), 0);
            tick();
        end
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        model_flip();
        chk("held_flip_done", 32'(swap_done), 1);
        wait_ready(0, 1'b0);
        tick();
        wr_valid = 1'b0;
        mm[1-mfront][20][3] = r3;
        do_read(4, 3);
        do_swap();
        do_read(4, 3);

        // Test 4: out-of-range writes are accepted and discarded
        do_write(32, 0, 3'b111);
        do_write(0, 32, 3'b111);
        do_write(63, 63, 3'b111);
        chk("oor_wr_ready", 32'(wr_ready), 1);
        do_swap();
        scan_front();

        // Test 5: read issued in the flip cycle returns old-bank data
        rr = $urandom_range(0, D-1);
        cc = $urandom_range(0, W-1);
        et = mm[mfront][rr][cc];
        eb = mm[mfront][rr+D][cc];
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        rd_en = 1'b1; rd_row = 5'(rr); rd_col = 5'(cc); frame_end = 1'b1;
        tick();
        rd_en = 1'b0; frame_end = 1'b0;
        model_flip();
        chk("flip_rd_top", 32'({R1_data, G1_data, B1_data}), 32'(et));
        chk("flip_rd_bot", 32'({R2_data, G2_data, B2_data}), 32'(eb));
        chk("flip_rd_valid", 32'(rd_valid), 1);
        chk("flip_rd_done", 32'(swap_done), 1);
        tick();
        chk("hold_rd_valid", 32'(rd_valid), 0);
        chk("hold_top", 32'({R1_data, G1_data, B1_data}), 32'(et));
        chk("hold_bot", 32'({R2_data, G2_data, B2_data}), 32'(eb));
        wait_ready(1, 1'b1);
        do_read(rr, cc);

`ifdef FB_CLEAR_ON_SWAP_EN
        // Test 6: reset in the middle of a clear restarts it from address 0
        if (mfront == 0) do_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        repeat (100) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        mfront = 0;
        for (int y = 0; y < 2*D; y++)
            for (int x = 0; x < W; x++)
                mm[1][y][x] = 3'b000;
        chk("midclr_rst_bank", 32'(front_bank), 0);
        chk("midclr_rst_pending", 32'(swap_pending), 0);
        wait_ready(0, 1'b1);
        do_swap();
        scan_front();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
